// File: rtl/mem_req_arbiter.sv
// Two-requester arbiter that issues one AXI4 burst at a time, with alternating priority on contention.
// Optional watchdog: define MEM_ARB_TIMEOUT_EN to abort a burst that stalls for TIMEOUT cycles.
module mem_req_arbiter #(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned AXI_ID_WIDTH   = 4,
    parameter int unsigned AXI_DATA_WIDTH = 32,
    parameter int unsigned TIMEOUT        = 1024
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    // requester command ports
    input  logic [1:0]                    req_valid_i,
    output logic [1:0]                    req_ready_o,
    input  logic [1:0]                    req_we_i,
    input  logic [2*ADDR_WIDTH-1:0]       req_addr_i,
    input  logic [15:0]                   req_len_i,
    // requester write data
    input  logic [2*AXI_DATA_WIDTH-1:0]   wr_data_i,
    input  logic [1:0]                    wr_valid_i,
    output logic [1:0]                    wr_ready_o,
    // requester read return
    output logic [AXI_DATA_WIDTH-1:0]     rd_data_o,
    output logic [1:0]                    rd_valid_o,
    output logic [1:0]                    rd_last_o,
    input  logic [1:0]                    rd_ready_i,
    output logic [1:0]                    done_o,
    output logic                          err_timeout_o,
    // AXI AW
    output logic [AXI_ID_WIDTH-1:0]       axi_awid_o,
    output logic [ADDR_WIDTH-1:0]         axi_awaddr_o,
    output logic [7:0]                    axi_awlen_o,
    output logic [2:0]                    axi_awsize_o,
    output logic [1:0]                    axi_awburst_o,
    output logic                          axi_awvalid_o,
    input  logic                          axi_awready_i,
    // AXI W
    output logic [AXI_DATA_WIDTH-1:0]     axi_wdata_o,
    output logic [AXI_DATA_WIDTH/8-1:0]   axi_wstrb_o,
    output logic                          axi_wlast_o,
    output logic                          axi_wvalid_o,
    input  logic                          axi_wready_i,
    // AXI B
    input  logic [AXI_ID_WIDTH-1:0]       axi_bid_i,
    input  logic [1:0]                    axi_bresp_i,
    input  logic                          axi_bvalid_i,
    output logic                          axi_bready_o,
    // AXI AR
    output logic [AXI_ID_WIDTH-1:0]       axi_arid_o,
    output logic [ADDR_WIDTH-1:0]         axi_araddr_o,
    output logic [7:0]                    axi_arlen_o,
    output logic [2:0]                    axi_arsize_o,
    output logic [1:0]                    axi_arburst_o,
    output logic                          axi_arvalid_o,
    input  logic                          axi_arready_i,
    // AXI R
    input  logic [AXI_ID_WIDTH-1:0]       axi_rid_i,
    input  logic [AXI_DATA_WIDTH-1:0]     axi_rdata_i,
    input  logic [1:0]                    axi_rresp_i,
    input  logic                          axi_rlast_i,
    input  logic                          axi_rvalid_i,
    output logic                          axi_rready_o
);

    localparam int unsigned STRB_WIDTH    = AXI_DATA_WIDTH / 8;
    localparam logic [2:0]  AX_SIZE       = 3'($clog2(STRB_WIDTH));
    localparam logic [1:0]  AX_BURST_INCR = 2'b01;

    typedef enum logic [2:0] {IDLE, AW, W, B, AR, R} state_e;

    typedef struct packed {
        logic                  we;
        logic [ADDR_WIDTH-1:0] addr;
        logic [7:0]            len;
    } cmd_t;

    state_e     state_q, state_d;
    cmd_t       cmd_q, cmd_d;
    logic       gnt_q, gnt_d;
    logic       last_grant_q, last_grant_d;
    logic [7:0] beat_q, beat_d;
    logic [1:0] done_q, done_d;
    logic       win;
    logic       tmo_hit;

    // On contention the requester that did not win last time gets the grant.
    assign win = (req_valid_i == 2'b11) ? ~last_grant_q : req_valid_i[1];

`ifdef MEM_ARB_TIMEOUT_EN
    logic [15:0] tmo_cnt_q, tmo_cnt_d;
    logic        err_q, err_d;

    always_comb begin
        tmo_hit   = (state_q != IDLE) && (tmo_cnt_q == 16'(TIMEOUT - 1));
        tmo_cnt_d = (state_q == IDLE) ? 16'd0 : tmo_cnt_q + 16'd1;
        err_d     = err_q | tmo_hit;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tmo_cnt_q <= 16'd0;
            err_q     <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            err_q     <= err_d;
        end
    end

    assign err_timeout_o = err_q;
`else
    logic unused_timeout;

    assign tmo_hit        = 1'b0;
    assign err_timeout_o  = 1'b0;
    assign unused_timeout = ^32'(TIMEOUT);
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            cmd_q        <= '0;
            gnt_q        <= 1'b0;
            last_grant_q <= 1'b1;
            beat_q       <= 8'd0;
            done_q       <= 2'b00;
        end else begin
            state_q      <= state_d;
            cmd_q        <= cmd_d;
            gnt_q        <= gnt_d;
            last_grant_q <= last_grant_d;
            beat_q       <= beat_d;
            done_q       <= done_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cmd_d         = cmd_q;
        gnt_d         = gnt_q;
        last_grant_d  = last_grant_q;
        beat_d        = beat_q;
        done_d        = 2'b00;
        req_ready_o   = 2'b00;
        wr_ready_o    = 2'b00;
        rd_valid_o    = 2'b00;
        rd_last_o     = 2'b00;
        axi_awvalid_o = 1'b0;
        axi_wvalid_o  = 1'b0;
        axi_bready_o  = 1'b0;
        axi_arvalid_o = 1'b0;
        axi_rready_o  = 1'b0;

        case (state_q)
            IDLE: begin
                beat_d = 8'd0;
                if (|req_valid_i) begin
                    req_ready_o[win] = 1'b1;
                    gnt_d            = win;
                    last_grant_d     = win;
                    cmd_d.we         = req_we_i[win];
                    cmd_d.addr       = win ? req_addr_i[2*ADDR_WIDTH-1:ADDR_WIDTH]
                                           : req_addr_i[ADDR_WIDTH-1:0];
                    cmd_d.len        = win ? req_len_i[15:8] : req_len_i[7:0];
                    state_d          = req_we_i[win] ? AW : AR;
                end
            end
            AW: begin
                axi_awvalid_o = 1'b1;
                if (axi_awready_i) state_d = W;
            end
            W: begin
                axi_wvalid_o      = wr_valid_i[gnt_q];
                wr_ready_o[gnt_q] = axi_wready_i;
                if (wr_valid_i[gnt_q] && axi_wready_i) begin
                    if (beat_q == cmd_q.len) state_d = B;
                    else                     beat_d  = beat_q + 8'd1;
                end
            end
            B: begin
                axi_bready_o = 1'b1;
                if (axi_bvalid_i) begin
                    done_d[gnt_q] = 1'b1;
                    state_d       = IDLE;
                end
            end
            AR: begin
                axi_arvalid_o = 1'b1;
                if (axi_arready_i) state_d = R;
            end
            R: begin
                rd_valid_o[gnt_q] = axi_rvalid_i;
                rd_last_o[gnt_q]  = axi_rlast_i;
                axi_rready_o      = rd_ready_i[gnt_q];
                if (axi_rvalid_i && rd_ready_i[gnt_q] && axi_rlast_i) begin
                    done_d[gnt_q] = 1'b1;
                    state_d       = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Watchdog abort: no handshake may complete in the expiry cycle.
        if (tmo_hit) begin
            wr_ready_o    = 2'b00;
            rd_valid_o    = 2'b00;
            rd_last_o     = 2'b00;
            axi_awvalid_o = 1'b0;
            axi_wvalid_o  = 1'b0;
            axi_bready_o  = 1'b0;
            axi_arvalid_o = 1'b0;
            axi_rready_o  = 1'b0;
            done_d        = 2'b00;
            beat_d        = 8'd0;
            state_d       = IDLE;
        end
    end

    assign done_o        = done_q;
    assign rd_data_o     = axi_rdata_i;

    assign axi_awid_o    = AXI_ID_WIDTH'(gnt_q);
    assign axi_awaddr_o  = cmd_q.addr;
    assign axi_awlen_o   = cmd_q.len;
    assign axi_awsize_o  = AX_SIZE;
    assign axi_awburst_o = AX_BURST_INCR;

    assign axi_arid_o    = AXI_ID_WIDTH'(gnt_q);
    assign axi_araddr_o  = cmd_q.addr;
    assign axi_arlen_o   = cmd_q.len;
    assign axi_arsize_o  = AX_SIZE;
    assign axi_arburst_o = AX_BURST_INCR;

    assign axi_wdata_o   = gnt_q ? wr_data_i[2*AXI_DATA_WIDTH-1:AXI_DATA_WIDTH]
                                 : wr_data_i[AXI_DATA_WIDTH-1:0];
    assign axi_wstrb_o   = '1;
    assign axi_wlast_o   = (beat_q == cmd_q.len);

    // Response IDs and status codes carry no information for a single-outstanding master.
    logic unused_inputs;
    assign unused_inputs = ^{axi_bid_i, axi_bresp_i, axi_rid_i, axi_rresp_i, cmd_q.we};

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed self-checking bench for mem_req_arbiter; slave-side AXI responses are driven by hand.
module tb_mem_req_arbiter;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int unsigned TB_TIMEOUT = 16;
`else
    localparam int unsigned TB_TIMEOUT = 1024;
`endif

    logic        clk_i;
    logic        rst_ni;
    logic [1:0]  req_valid_i, req_ready_o, req_we_i;
    logic [63:0] req_addr_i;
    logic [15:0] req_len_i;
    logic [63:0] wr_data_i;
    logic [1:0]  wr_valid_i, wr_ready_o;
    logic [31:0] rd_data_o;
    logic [1:0]  rd_valid_o, rd_last_o, rd_ready_i, done_o;
    logic        err_timeout_o;
    logic [3:0]  axi_awid_o, axi_arid_o, axi_bid_i, axi_rid_i;
    logic [31:0] axi_awaddr_o, axi_araddr_o, axi_wdata_o, axi_rdata_i;
    logic [7:0]  axi_awlen_o, axi_arlen_o;
    logic [2:0]  axi_awsize_o, axi_arsize_o;
    logic [1:0]  axi_awburst_o, axi_arburst_o, axi_bresp_i, axi_rresp_i;
    logic [3:0]  axi_wstrb_o;
    logic        axi_awvalid_o, axi_awready_i, axi_wlast_o, axi_wvalid_o, axi_wready_i;
    logic        axi_bvalid_i, axi_bready_o, axi_arvalid_o, axi_arready_i;
    logic        axi_rlast_i, axi_rvalid_i, axi_rready_o;

    int n_cmp = 0;
    int n_err = 0;

    mem_req_arbiter #(
        .ADDR_WIDTH(32), .AXI_ID_WIDTH(4), .AXI_DATA_WIDTH(32), .TIMEOUT(TB_TIMEOUT)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
        .req_addr_i(req_addr_i), .req_len_i(req_len_i),
        .wr_data_i(wr_data_i), .wr_valid_i(wr_valid_i), .wr_ready_o(wr_ready_o),
        .rd_data_o(rd_data_o), .rd_valid_o(rd_valid_o), .rd_last_o(rd_last_o),
        .rd_ready_i(rd_ready_i), .done_o(done_o), .err_timeout_o(err_timeout_o),
        .axi_awid_o(axi_awid_o), .axi_awaddr_o(axi_awaddr_o), .axi_awlen_o(axi_awlen_o),
        .axi_awsize_o(axi_awsize_o), .axi_awburst_o(axi_awburst_o),
        .axi_awvalid_o(axi_awvalid_o), .axi_awready_i(axi_awready_i),
        .axi_wdata_o(axi_wdata_o), .axi_wstrb_o(axi_wstrb_o), .axi_wlast_o(axi_wlast_o),
        .axi_wvalid_o(axi_wvalid_o), .axi_wready_i(axi_wready_i),
        .axi_bid_i(axi_bid_i), .axi_bresp_i(axi_bresp_i), .axi_bvalid_i(axi_bvalid_i),
        .axi_bready_o(axi_bready_o),
        .axi_arid_o(axi_arid_o), .axi_araddr_o(axi_araddr_o), .axi_arlen_o(axi_arlen_o),
        .axi_arsize_o(axi_arsize_o), .axi_arburst_o(axi_arburst_o),
        .axi_arvalid_o(axi_arvalid_o), .axi_arready_i(axi_arready_i),
        .axi_rid_i(axi_rid_i), .axi_rdata_i(axi_rdata_i), .axi_rresp_i(axi_rresp_i),
        .axi_rlast_i(axi_rlast_i), .axi_rvalid_i(axi_rvalid_i), .axi_rready_o(axi_rready_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic idle_inputs();
        req_valid_i = '0; req_we_i = '0; req_addr_i = '0; req_len_i = '0;
        wr_data_i = '0; wr_valid_i = '0; rd_ready_i = '0;
        axi_awready_i = 0; axi_wready_i = 0; axi_arready_i = 0;
        axi_bid_i = '0; axi_bresp_i = '0; axi_bvalid_i = 0;
        axi_rid_i = '0; axi_rdata_i = '0; axi_rresp_i = '0; axi_rlast_i = 0; axi_rvalid_i = 0;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        idle_inputs();
        repeat (2) @(negedge clk_i);
        #1;
        n_cmp++; if (req_ready_o !== 2'b00) begin n_err++; $display("FAIL rst_req_ready: got %b want 00", req_ready_o); end
        n_cmp++; if ({axi_awvalid_o, axi_wvalid_o, axi_arvalid_o} !== 3'b000) begin n_err++; $display("FAIL rst_valids: got %b want 000", {axi_awvalid_o, axi_wvalid_o, axi_arvalid_o}); end
        n_cmp++; if ({axi_bready_o, axi_rready_o} !== 2'b00) begin n_err++; $display("FAIL rst_readies: got %b want 00", {axi_bready_o, axi_rready_o}); end
        n_cmp++; if (done_o !== 2'b00) begin n_err++; $display("FAIL rst_done: got %b want 00", done_o); end
        n_cmp++; if (err_timeout_o !== 1'b0) begin n_err++; $display("FAIL rst_err: got %b want 0", err_timeout_o); end
        @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    task automatic test_write();
        idle_inputs();
        axi_awready_i = 1; axi_wready_i = 1;
        req_valid_i = 2'b01; req_we_i = 2'b01; req_addr_i[31:0] = 32'h100; req_len_i[7:0] = 8'd3;
        #1;
        n_cmp++; if (req_ready_o !== 2'b01) begin n_err++; $display("FAIL wr_grant: got %b want 01", req_ready_o); end
        @(negedge clk_i);
        req_valid_i = 2'b00;
        #1;
        n_cmp++; if (axi_awvalid_o !== 1'b1) begin n_err++; $display("FAIL wr_awvalid: got %b want 1", axi_awvalid_o); end
        n_cmp++; if (axi_awaddr_o !== 32'h100) begin n_err++; $display("FAIL wr_awaddr: got %h want 100", axi_awaddr_o); end
        n_cmp++; if (axi_awid_o !== 4'd0) begin n_err++; $display("FAIL wr_awid: got %h want 0", axi_awid_o); end
        n_cmp++; if (axi_awlen_o !== 8'd3) begin n_err++; $display("FAIL wr_awlen: got %h want 3", axi_awlen_o); end
        n_cmp++; if ({axi_awsize_o, axi_awburst_o} !== {3'd2, 2'b01}) begin n_err++; $display("FAIL wr_size_burst: got %h/%b want 2/01", axi_awsize_o, axi_awburst_o); end
        n_cmp++; if (req_ready_o !== 2'b00) begin n_err++; $display("FAIL wr_ready_busy: got %b want 00", req_ready_o); end
        // cycle 1 stalls with WREADY low, so beat 1 repeats
        for (int c = 0; c < 5; c++) begin
            int   b;
            logic wr;
            @(negedge clk_i);
            b  = (c <= 1) ? c : c - 1;
            wr = (c != 1);
            axi_wready_i = wr;
            wr_valid_i   = 2'b11;
            wr_data_i    = {32'hDEAD_0000 + 32'(c), 32'h0000_00A0 + 32'(b)};
            #1;
            n_cmp++; if (axi_wdata_o !== 32'h0000_00A0 + 32'(b)) begin n_err++; $display("FAIL wr_wdata c%0d: got %h want %h", c, axi_wdata_o, 32'hA0 + 32'(b)); end
            n_cmp++; if (axi_wlast_o !== (b == 3)) begin n_err++; $display("FAIL wr_wlast c%0d: got %b want %b", c, axi_wlast_o, (b == 3)); end
            n_cmp++; if ({axi_wvalid_o, wr_ready_o} !== {1'b1, 1'b0, wr}) begin n_err++; $display("FAIL wr_hs c%0d: got %b/%b want 1/0%b", c, axi_wvalid_o, wr_ready_o, wr); end
        end
        n_cmp++; if (axi_wstrb_o !== 4'hF) begin n_err++; $display("FAIL wr_wstrb: got %h want f", axi_wstrb_o); end
        @(negedge clk_i);
        wr_valid_i = 2'b00; axi_bvalid_i = 1;
        #1;
        n_cmp++; if ({axi_bready_o, axi_wvalid_o, done_o} !== 4'b1000) begin n_err++; $display("FAIL wr_bphase: got %b want 1000", {axi_bready_o, axi_wvalid_o, done_o}); end
        @(negedge clk_i);
        axi_bvalid_i = 0;
        #1;
        n_cmp++; if (done_o !== 2'b01) begin n_err++; $display("FAIL wr_done: got %b want 01", done_o); end
        n_cmp++; if (axi_bready_o !== 1'b0) begin n_err++; $display("FAIL wr_idle_bready: got %b want 0", axi_bready_o); end
        @(negedge clk_i);
        #1;
        n_cmp++; if (done_o !== 2'b00) begin n_err++; $display("FAIL wr_done_pulse: got %b want 00", done_o); end
    endtask

    task automatic test_alternate();
        logic [1:0] prev;
        idle_inputs();
        axi_arready_i = 1; rd_ready_i = 2'b11; req_valid_i = 2'b11;
        req_addr_i = {32'h300, 32'h200};
        prev = 2'b00;
        for (int k = 0; k < 4; k++) begin
            logic       e;
            logic [1:0] oh;
            e  = (k % 2) == 1;
            oh = e ? 2'b10 : 2'b01;
            axi_rvalid_i = 0; axi_rlast_i = 0;
            #1;
            n_cmp++; if (req_ready_o !== oh) begin n_err++; $display("FAIL alt_grant k%0d: got %b want %b", k, req_ready_o, oh); end
            if (k > 0) begin
                n_cmp++; if (done_o !== prev) begin n_err++; $display("FAIL alt_done k%0d: got %b want %b", k, done_o, prev); end
            end
            @(negedge clk_i);
            #1;
            n_cmp++; if ({axi_arvalid_o, axi_arid_o} !== {1'b1, 3'b000, e}) begin n_err++; $display("FAIL alt_ar k%0d: got %b/%h want 1/%0d", k, axi_arvalid_o, axi_arid_o, e); end
            n_cmp++; if (axi_araddr_o !== (e ? 32'h300 : 32'h200)) begin n_err++; $display("FAIL alt_araddr k%0d: got %h", k, axi_araddr_o); end
            @(negedge clk_i);
            axi_rvalid_i = 1; axi_rlast_i = 1; axi_rdata_i = 32'h5500 + 32'(k);
            #1;
            n_cmp++; if ({rd_valid_o, rd_last_o, axi_rready_o} !== {oh, oh, 1'b1}) begin n_err++; $display("FAIL alt_r k%0d: got %b want %b", k, {rd_valid_o, rd_last_o, axi_rready_o}, {oh, oh, 1'b1}); end
            n_cmp++; if (rd_data_o !== 32'h5500 + 32'(k)) begin n_err++; $display("FAIL alt_rdata k%0d: got %h", k, rd_data_o); end
            prev = oh;
            @(negedge clk_i);
        end
        req_valid_i = 2'b00; axi_rvalid_i = 0; axi_rlast_i = 0;
        #1;
        n_cmp++; if (done_o !== 2'b10) begin n_err++; $display("FAIL alt_done_last: got %b want 10", done_o); end
        @(negedge clk_i);
    endtask

    task automatic test_read_stall();
        idle_inputs();
        axi_arready_i = 1;
        req_valid_i = 2'b10; req_addr_i[63:32] = 32'h400;
        #1;
        n_cmp++; if (req_ready_o !== 2'b10) begin n_err++; $display("FAIL rs_grant: got %b want 10", req_ready_o); end
        @(negedge clk_i);
        req_valid_i = 2'b00;
        #1;
        n_cmp++; if ({axi_arid_o, axi_araddr_o, axi_arlen_o} !== {4'd1, 32'h400, 8'd0}) begin n_err++; $display("FAIL rs_ar: got %h/%h/%h want 1/400/0", axi_arid_o, axi_araddr_o, axi_arlen_o); end
        for (int s = 0; s < 6; s++) begin
            @(negedge clk_i);
            axi_rvalid_i = 1; axi_rlast_i = 1; axi_rdata_i = 32'hBEEF;
            rd_ready_i = (s < 5) ? 2'b01 : 2'b10;
            #1;
            n_cmp++; if (axi_rready_o !== (s == 5)) begin n_err++; $display("FAIL rs_rready s%0d: got %b want %b", s, axi_rready_o, (s == 5)); end
            n_cmp++; if ({rd_valid_o, rd_last_o, done_o} !== 6'b101000) begin n_err++; $display("FAIL rs_rd s%0d: got %b want 101000", s, {rd_valid_o, rd_last_o, done_o}); end
        end
        @(negedge clk_i);
        axi_rvalid_i = 0; axi_rlast_i = 0;
        #1;
        n_cmp++; if ({done_o, rd_valid_o} !== 4'b1000) begin n_err++; $display("FAIL rs_done: got %b want 1000", {done_o, rd_valid_o}); end
        @(negedge clk_i);
    endtask

    task automatic test_reset_midburst();
        idle_inputs();
        axi_awready_i = 1; axi_wready_i = 1;
        req_valid_i = 2'b01; req_we_i = 2'b01; req_addr_i[31:0] = 32'h800; req_len_i[7:0] = 8'd7;
        #1;
        n_cmp++; if (req_ready_o !== 2'b01) begin n_err++; $display("FAIL mr_grant: got %b want 01", req_ready_o); end
        @(negedge clk_i);
        req_valid_i = 2'b00;
        @(negedge clk_i);
        wr_valid_i = 2'b01;
        repeat (2) @(negedge clk_i);
        #1;
        n_cmp++; if (axi_wvalid_o !== 1'b1) begin n_err++; $display("FAIL mr_beat2: got %b want 1", axi_wvalid_o); end
        rst_ni = 1'b0;
        #1;
        n_cmp++; if ({axi_awvalid_o, axi_wvalid_o, axi_arvalid_o, axi_bready_o, wr_ready_o, done_o} !== 8'd0) begin n_err++; $display("FAIL mr_async: got %b want 00000000", {axi_awvalid_o, axi_wvalid_o, axi_arvalid_o, axi_bready_o, wr_ready_o, done_o}); end
        @(negedge clk_i);
        rst_ni = 1'b1;
        wr_valid_i = 2'b00; axi_arready_i = 1;
        req_valid_i = 2'b01; req_we_i = 2'b00; req_addr_i[31:0] = 32'h500; req_len_i = 16'd0;
        #1;
        n_cmp++; if (req_ready_o !== 2'b01) begin n_err++; $display("FAIL mr_regrant: got %b want 01", req_ready_o); end
        @(negedge clk_i);
        req_valid_i = 2'b00;
        #1;
        n_cmp++; if ({axi_arvalid_o, axi_araddr_o} !== {1'b1, 32'h500}) begin n_err++; $display("FAIL mr_ar: got %b/%h want 1/500", axi_arvalid_o, axi_araddr_o); end
        @(negedge clk_i);
        axi_rvalid_i = 1; axi_rlast_i = 1; rd_ready_i = 2'b01;
        @(negedge clk_i);
        axi_rvalid_i = 0; axi_rlast_i = 0;
        #1;
        n_cmp++; if (done_o !== 2'b01) begin n_err++; $display("FAIL mr_done: got %b want 01", done_o); end
        @(negedge clk_i);
    endtask

    task automatic test_len255();
        int nlast;
        int lastidx;
        idle_inputs();
        axi_awready_i = 1; axi_wready_i = 1;
        req_valid_i = 2'b10; req_we_i = 2'b10; req_addr_i[63:32] = 32'h1000; req_len_i[15:8] = 8'd255;
        nlast = 0; lastidx = -1;
        #1;
        n_cmp++; if (req_ready_o !== 2'b10) begin n_err++; $display("FAIL l255_grant: got %b want 10", req_ready_o); end
        @(negedge clk_i);
        req_valid_i = 2'b00;
        #1;
        n_cmp++; if ({axi_awid_o, axi_awlen_o} !== {4'd1, 8'd255}) begin n_err++; $display("FAIL l255_aw: got %h/%h want 1/ff", axi_awid_o, axi_awlen_o); end
        for (int i = 0; i < 256; i++) begin
            @(negedge clk_i);
            wr_valid_i = 2'b10; wr_data_i = {32'(i), 32'hFFFF_FFFF};
            #1;
            n_cmp++; if (axi_wdata_o !== 32'(i)) begin n_err++; $display("FAIL l255_wdata i%0d: got %h", i, axi_wdata_o); end
            if (axi_wlast_o === 1'b1) begin nlast++; lastidx = i; end
        end
        n_cmp++; if ({nlast, lastidx} !== {32'd1, 32'd255}) begin n_err++; $display("FAIL l255_wlast: got count %0d at %0d want 1 at 255", nlast, lastidx); end
        @(negedge clk_i);
        wr_valid_i = 2'b00; axi_bvalid_i = 1;
        #1;
        n_cmp++; if (axi_bready_o !== 1'b1) begin n_err++; $display("FAIL l255_bready: got %b want 1", axi_bready_o); end
        @(negedge clk_i);
        axi_bvalid_i = 0;
        #1;
        n_cmp++; if (done_o !== 2'b10) begin n_err++; $display("FAIL l255_done: got %b want 10", done_o); end
        @(negedge clk_i);
    endtask

    task automatic test_timeout();
        idle_inputs();
        axi_awready_i = 1; axi_wready_i = 1; wr_valid_i = 2'b01;
        req_valid_i = 2'b01; req_we_i = 2'b01; req_addr_i[31:0] = 32'h40;
        #1;
        n_cmp++; if (req_ready_o !== 2'b01) begin n_err++; $display("FAIL to_grant: got %b want 01", req_ready_o); end
        for (int n = 1; n <= 16; n++) begin
            @(negedge clk_i);
            req_valid_i = 2'b00;
            #1;
            if (n == 1) begin
                n_cmp++; if (axi_awvalid_o !== 1'b1) begin n_err++; $display("FAIL to_aw: got %b want 1", axi_awvalid_o); end
            end
            if (n == 2) begin
                n_cmp++; if ({axi_wvalid_o, axi_wlast_o} !== 2'b11) begin n_err++; $display("FAIL to_w: got %b want 11", {axi_wvalid_o, axi_wlast_o}); end
            end
            if (n == 3) begin
                n_cmp++; if (axi_bready_o !== 1'b1) begin n_err++; $display("FAIL to_b: got %b want 1", axi_bready_o); end
            end
            n_cmp++; if (err_timeout_o !== 1'b0) begin n_err++; $display("FAIL to_err_early n%0d: got %b want 0", n, err_timeout_o); end
        end
        @(negedge clk_i);
        #1;
`ifdef MEM_ARB_TIMEOUT_EN
        n_cmp++; if ({err_timeout_o, axi_bready_o, done_o} !== 4'b1000) begin n_err++; $display("FAIL to_fire: got %b want 1000", {err_timeout_o, axi_bready_o, done_o}); end
`else
        n_cmp++; if ({err_timeout_o, axi_bready_o} !== 2'b01) begin n_err++; $display("FAIL to_hold: got %b want 01", {err_timeout_o, axi_bready_o}); end
`endif
        @(negedge clk_i);
        #1;
`ifdef MEM_ARB_TIMEOUT_EN
        n_cmp++; if ({err_timeout_o, done_o, req_ready_o} !== 5'b10000) begin n_err++; $display("FAIL to_sticky: got %b want 10000", {err_timeout_o, done_o, req_ready_o}); end
`else
        n_cmp++; if ({err_timeout_o, axi_bready_o, done_o} !== 4'b0100) begin n_err++; $display("FAIL to_stay_b: got %b want 0100", {err_timeout_o, axi_bready_o, done_o}); end
`endif
    endtask

    initial begin
        test_reset();
        test_write();
        test_reset();
        test_alternate();
        test_read_stall();
        test_reset_midburst();
`ifndef MEM_ARB_TIMEOUT_EN
        test_len255();
`endif
        test_timeout();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_req_arbiter.md
MEM_REQ_ARBITER -- requirements
Module: mem_req_arbiter

Interface
REQ-001 Params SHALL be: ADDR_WIDTH, 32, AXI byte address width; AXI_ID_WIDTH, 4, ID width (>=1); AXI_DATA_WIDTH, 32, data width; TIMEOUT, 1024, watchdog limit in cycles.
REQ-002 Clocking SHALL be: one clock; reset is asynchronous and active-low.
REQ-003 clk_i  in  1  sole clock, rising edge.
REQ-004 rst_ni  in  1  async active-low reset.
REQ-005 req_valid_i/req_ready_o  in/out  2 each  command handshake, bit n = requester n.
REQ-006 req_we_i  in  2  1 = write burst, 0 = read burst.
REQ-007 req_addr_i  in  2*ADDR_WIDTH  byte address, requester n in slice n.
REQ-008 req_len_i  in  16  AXI LEN (beats-1), 8 bits per requester.
REQ-009 wr_data_i  in  2*AXI_DATA_WIDTH; wr_valid_i in 2; wr_ready_o out 2  write data streams.
REQ-010 rd_data_o  out  AXI_DATA_WIDTH; rd_valid_o/rd_last_o out 2; rd_ready_i in 2  read return streams.
REQ-011 done_o  out  2  one-cycle pulse when requester n's burst completes.
REQ-012 err_timeout_o  out  1  sticky watchdog flag.
REQ-013 AXI master ports SHALL be: AW (ID, ADDR, LEN, SIZE, BURST, VALID out; READY in), W (DATA, STRB, LAST, VALID out; READY in), B (ID, RESP, VALID in; READY out), AR (as AW), R (ID, DATA, RESP, LAST, VALID in; READY out).

Function
REQ-014 FSM states SHALL be IDLE, AW, W, B, AR, R; exactly one burst outstanding at a time.
REQ-015 In IDLE with any req_valid_i set, winner SHALL be the sole requester, or on contention the requester != last_grant; req_ready_o[winner]=1 that cycle only, command latched, last_grant<=winner, next state AW (we=1) or AR (we=0).
REQ-016 req_ready_o SHALL be 0 in every non-IDLE state.
REQ-017 AW/AR: AxVALID=1 from latched command; AxID=winner index zero-extended; AxSIZE=log2(AXI_DATA_WIDTH/8); AxBURST=2'b01; hold until AxREADY, then go W or R.
REQ-018 W: WDATA/WVALID SHALL mux from granted requester, wr_ready_o[winner]=WREADY, other bit 0; WSTRB all ones; 8-bit beat counter from 0; WLAST=1 when counter==LEN; on WLAST handshake go B.
REQ-019 B: BREADY=1; on BVALID pulse done_o[winner], go IDLE; BRESP ignored.
REQ-020 R: rd_data_o=RDATA; rd_valid_o[winner]=RVALID, rd_last_o[winner]=RLAST, other bits 0; RREADY=rd_ready_i[winner]; on RLAST handshake pulse done_o[winner], go IDLE.
REQ-021 Back-to-back: a new grant SHALL occur at earliest the cycle after return to IDLE (min. 1 idle cycle between bursts).
REQ-022 LEN=0 SHALL give single beat with WLAST/RLAST on beat 0; LEN=255 SHALL give 256 beats without counter wrap error.
REQ-023 Requester dropping req_valid_i before grant SHALL be legal and lose arbitration; inputs of non-granted requester SHALL be ignored.

Reset
REQ-024 Async assert of rst_ni SHALL force IDLE, beat counter 0, last_grant=1 (requester 0 wins first contention), err_timeout_o=0, all VALID/READY/done outputs 0, mid-burst included.
REQ-025 Reset deassertion SHALL be synchronised externally; first grant possible on first edge after release.

Configuration
REQ-026 Macro MEM_ARB_TIMEOUT_EN defined: 16-bit counter clears in IDLE, increments each non-IDLE cycle; reaching TIMEOUT SHALL set err_timeout_o (sticky until reset), drop all AXI VALID/READY outputs, return to IDLE without done_o.
REQ-027 MEM_ARB_TIMEOUT_EN undefined: no counter, err_timeout_o tied 0, FSM waits indefinitely.

Verification
REQ-028 Req0 write addr 0x100 LEN 3, slave ready always -> AWADDR 0x100 AWID 0, 4 W beats, WLAST on 4th, done_o=01 one cycle after BVALID.
REQ-029 Req0 and req1 read simultaneously from reset -> req0 granted first, req1 next; repeat -> alternation 0,1,0,1 over 4 bursts.
REQ-030 Req1 read LEN 0, rd_ready_i[1] low 5 cycles -> RREADY low 5 cycles, single beat with rd_last_o[1]=1, done_o=10.
REQ-031 rst_ni low during W beat 2 of LEN 7 write -> all valids 0 immediately; after release new req0 command granted in IDLE.
REQ-032 MEM_ARB_TIMEOUT_EN, TIMEOUT=16, BVALID never -> err_timeout_o=1 after 16 non-IDLE cycles, FSM IDLE, no done_o; undefined -> stays in B, err_timeout_o=0.
